// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store memory initiator
// Contents: access size codes, response error codes, initiator FSM states,
// timeout counter width.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_X = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_ERR_OK       = 2'd0,
        LSU_ERR_MISALIGN = 2'd1,
        LSU_ERR_TIMEOUT  = 2'd2
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam int LSU_CNT_W = 16;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// rtl/lsu_mem_initiator_if.sv - word-aligned data-memory request/response bus
// Signals: mem_valid/mem_ready request handshake carrying mem_wen, mem_addr,
// mem_wdata, mem_wmask; mem_rvalid/mem_rdata response (read data or write ack).
// Modports: master = initiator (LSU), slave = RAM/bus responder.
interface lsu_mem_initiator_if;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane alignment for loads and stores
// Inputs:  offset (addr[1:0]), size, is_unsigned, wdata (LSB-aligned store data),
//          rdata (full memory word).
// Outputs: wmask (byte lanes), wdata_rep (lane-replicated store data),
//          misalign (illegal size or unaligned half/word), rdata_ext (extended load).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        // Bring the addressed byte/half down to bit 0 before extending.
        shifted   = rdata >> {offset, 3'b000};
        wmask     = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        rdata_ext = 32'h0;
        case (size)
            LSU_SIZE_B: begin
                wmask     = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_SIZE_H: begin
                wmask     = 4'b0011 << offset;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = offset[0];
                rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            LSU_SIZE_W: begin
                wmask     = 4'b1111;
                misalign  = |offset;
                rdata_ext = shifted;
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - single-outstanding load/store initiator for the data-memory port
// Ports: clock, reset (sync, active-high); req_* core request (valid/ready, wen,
// addr, wdata, size, unsigned); resp_* core response (valid/ready, rdata, err);
// mem (lsu_mem_initiator_if.master) word-aligned memory bus.
// Parameter TIMEOUT_CYCLES: cycles allowed in REQ+WAIT before a timeout error.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    lsu_mem_initiator_if.master mem
);

    localparam logic [LSU_CNT_W-1:0] TMO = LSU_CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e           state;
    logic                 r_wen;
    logic [1:0]           r_off;
    lsu_size_e            r_size;
    logic                 r_unsigned;
    logic [LSU_CNT_W-1:0] cnt;

    logic        is_idle;
    logic [1:0]  a_off;
    lsu_size_e   a_size;
    logic        a_uns;
    logic [3:0]  a_wmask;
    logic [31:0] a_wdata;
    logic        a_misalign;
    logic [31:0] a_rdata;

    // One aligner serves both phases: in IDLE it sees the incoming request
    // (mask/data/misalign), afterwards the latched fields (load extraction).
    assign is_idle = (state == ST_IDLE);
    assign a_off   = is_idle ? req_addr[1:0]          : r_off;
    assign a_size  = is_idle ? lsu_size_e'(req_size)  : r_size;
    assign a_uns   = is_idle ? req_unsigned           : r_unsigned;

    lsu_align u_align (
        .offset      (a_off),
        .size        (a_size),
        .is_unsigned (a_uns),
        .wdata       (req_wdata),
        .rdata       (mem.mem_rdata),
        .wmask       (a_wmask),
        .wdata_rep   (a_wdata),
        .misalign    (a_misalign),
        .rdata_ext   (a_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            mem.mem_valid <= 1'b0;
            mem.mem_wen   <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_wmask <= 4'h0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0;
            resp_err      <= LSU_ERR_OK;
            cnt           <= '0;
            r_wen         <= 1'b0;
            r_off         <= 2'b00;
            r_size        <= LSU_SIZE_B;
            r_unsigned    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_wen      <= req_wen;
                        r_off      <= req_addr[1:0];
                        r_size     <= lsu_size_e'(req_size);
                        r_unsigned <= req_unsigned;
                        if (a_misalign) begin
                            // Rejected without touching the memory bus.
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_err   <= LSU_ERR_MISALIGN;
                        end else begin
                            state         <= ST_REQ;
                            cnt           <= '0;
                            mem.mem_valid <= 1'b1;
                            mem.mem_wen   <= req_wen;
                            mem.mem_addr  <= {req_addr[31:2], 2'b00};
                            mem.mem_wdata <= a_wdata;
                            mem.mem_wmask <= a_wmask;
                        end
                    end
                end
                ST_REQ: begin
                    if (cnt == TMO) begin
                        mem.mem_valid <= 1'b0;
                        state         <= ST_RESP;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= 32'h0;
                        resp_err      <= LSU_ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // An rvalid in this same cycle is ignored; only WAIT samples it.
                        if (mem.mem_ready) begin
                            mem.mem_valid <= 1'b0;
                            state         <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == TMO) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                        resp_err   <= LSU_ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (mem.mem_rvalid) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= r_wen ? 32'h0 : a_rdata;
                            resp_err   <= LSU_ERR_OK;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= LSU_ERR_OK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - scoreboard bench for lsu_mem_initiator
module tb_lsu_mem_initiator;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT 1: default timeout
    logic        req_valid = 0, req_wen = 0, req_unsigned = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [1:0]  req_size = 0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    lsu_mem_initiator_if m1 ();

    // DUT 2: short timeout
    logic        req_valid2 = 0, req_wen2 = 0, req_unsigned2 = 0, resp_ready2 = 0;
    logic [31:0] req_addr2 = 0, req_wdata2 = 0;
    logic [1:0]  req_size2 = 0;
    logic        req_ready2, resp_valid2;
    logic [31:0] resp_rdata2;
    logic [1:0]  resp_err2;
    lsu_mem_initiator_if m2 ();

    lsu_mem_initiator dut (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem(m1)
    );

    lsu_mem_initiator #(.TIMEOUT_CYCLES(8)) dut_tmo (
        .clock(clk), .reset(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wen(req_wen2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_size(req_size2),
        .req_unsigned(req_unsigned2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .mem(m2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
        logic [7:0]  by [4];
        logic [7:0]  b;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        b = by[lane];
        h = {by[(lane + 2'd1)], by[lane]};
        case (size)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] lane, input logic [1:0] size);
        int nb;
        logic [3:0] m;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) m[i] = (i >= int'(lane)) && (i < int'(lane) + nb);
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] size);
        int nb;
        logic [31:0] o;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % nb) +: 8];
        return o;
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_req_ready"},  req_ready, 1);
        check_eq({pfx, "_mem_valid"},  m1.mem_valid, 0);
        check_eq({pfx, "_mem_wen"},    m1.mem_wen, 0);
        check_eq({pfx, "_mem_addr"},   m1.mem_addr, 0);
        check_eq({pfx, "_mem_wdata"},  m1.mem_wdata, 0);
        check_eq({pfx, "_mem_wmask"},  m1.mem_wmask, 0);
        check_eq({pfx, "_resp_valid"}, resp_valid, 0);
        check_eq({pfx, "_resp_rdata"}, resp_rdata, 0);
        check_eq({pfx, "_resp_err"},   resp_err, 0);
    endtask

    task automatic run_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns, input logic [31:0] rword,
                              input int rdy_dly, input int rv_dly, input int rr_dly, input bit early_rv,
                              input logic [31:0] e_rdata, input logic [1:0] e_err, input int e_cycle,
                              input logic [3:0] e_mask, input logic [31:0] e_wdata);
        exp_t e;
        int   cyc, req_cnt, hs_cyc, rsp_cnt;
        bit   seen, done;
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        e.rdata = e_rdata; e.err = e_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 0;
        cyc = 1; req_cnt = 0; hs_cyc = -1; rsp_cnt = 0; seen = 0; done = 0;
        while (!done && cyc < 100) begin
            m1.mem_ready = 0; m1.mem_rvalid = 0; m1.mem_rdata = 32'hA5A5_5A5A; resp_ready = 0;
            check_eq("req_ready_busy", req_ready, 0);
            if (e_err == 2'd1) check_eq("mem_valid_misalign", m1.mem_valid, 0);
            if (m1.mem_valid) begin
                check_eq("mem_addr", m1.mem_addr, {addr[31:2], 2'b00});
                check_eq("mem_wen", m1.mem_wen, wen);
                check_eq("mem_wmask", m1.mem_wmask, e_mask);
                if (wen) check_eq("mem_wdata", m1.mem_wdata, e_wdata);
                if (req_cnt == rdy_dly) begin
                    m1.mem_ready = 1;
                    hs_cyc = cyc;
                    if (early_rv) begin
                        m1.mem_rvalid = 1;
                        m1.mem_rdata  = ~rword;
                    end
                end
                req_cnt++;
            end
            if (hs_cyc >= 0 && cyc == hs_cyc + rv_dly) begin
                m1.mem_rvalid = 1;
                m1.mem_rdata  = rword;
            end
            if (resp_valid) begin
                if (!seen) begin
                    check_eq("resp_cycle", cyc, e_cycle);
                    seen = 1;
                end
                if (rsp_cnt == rr_dly) begin
                    resp_ready = 1;
                    e = sb.pop_front();
                    check_eq("resp_rdata", resp_rdata, e.rdata);
                    check_eq("resp_err", resp_err, e.err);
                    done = 1;
                end else begin
                    check_eq("resp_rdata_hold", resp_rdata, sb[0].rdata);
                    check_eq("resp_err_hold", resp_err, sb[0].err);
                end
                rsp_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        m1.mem_ready = 0; m1.mem_rvalid = 0; resp_ready = 0;
        check_eq("access_done", done, 1);
        if (done) begin
            check_eq("req_ready_after", req_ready, 1);
            check_eq("resp_valid_after", resp_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] a, w, rw;
        logic [1:0]  sz, lane;
        logic        we, us;
        int          rd, rv, rr;
        exp_t        e;

        m1.mem_ready = 0; m1.mem_rvalid = 0; m1.mem_rdata = 0;
        m2.mem_ready = 0; m2.mem_rvalid = 0; m2.mem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check_reset_vals("rst");

        // Aligned word store, zero-wait
        run_access(1, 32'h8000_0004, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0, 1, 0, 0,
                   32'h0, 2'd0, 3, 4'hF, 32'hDEADBEEF);
        // Byte store to lane 3
        run_access(1, 32'h8000_0003, 32'h12345678, 2'd0, 0, 32'h0, 0, 1, 0, 0,
                   32'h0, 2'd0, 3, 4'b1000, 32'h78787878);
        // Signed and unsigned half loads from upper half
        run_access(0, 32'h8000_0002, 32'h0, 2'd1, 0, 32'h8001_7FFF, 0, 1, 0, 0,
                   32'hFFFF8001, 2'd0, 3, 4'b1100, 32'h0);
        run_access(0, 32'h8000_0002, 32'h0, 2'd1, 1, 32'h8001_7FFF, 0, 1, 0, 0,
                   32'h00008001, 2'd0, 3, 4'b1100, 32'h0);
        // Misaligned word, misaligned half, illegal size
        run_access(0, 32'h8000_0001, 32'h0, 2'd2, 0, 32'h0, 0, 1, 0, 0,
                   32'h0, 2'd1, 1, 4'h0, 32'h0);
        run_access(0, 32'h8000_0003, 32'h0, 2'd1, 0, 32'h0, 0, 1, 0, 0,
                   32'h0, 2'd1, 1, 4'h0, 32'h0);
        run_access(0, 32'h8000_0000, 32'h0, 2'd3, 0, 32'h0, 0, 1, 0, 0,
                   32'h0, 2'd1, 1, 4'h0, 32'h0);
        // Stalls: ready after 5 cycles, rvalid 3 later, resp_ready late by 2
        run_access(0, 32'h8000_0001, 32'h0, 2'd0, 0, 32'h0000_9A00, 5, 3, 2, 0,
                   32'hFFFFFF9A, 2'd0, 10, 4'b0010, 32'h0);
        // rvalid coincident with mem_ready must be ignored
        run_access(0, 32'h8000_0008, 32'h0, 2'd2, 0, 32'hCAFE_F00D, 1, 2, 1, 1,
                   32'hCAFEF00D, 2'd0, 5, 4'hF, 32'h0);

        // Randomised aligned accesses against the reference model
        for (int k = 0; k < 12; k++) begin
            we = 1'($urandom_range(0, 1));
            us = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            lane = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? 2'($urandom_range(0, 1)) << 1 : 2'd0;
            a  = 32'h1000_0000 | ($urandom & 32'h0000_FFF0) | {30'h0, lane};
            w  = $urandom;
            rw = $urandom;
            rd = $urandom_range(0, 2);
            rv = $urandom_range(1, 2);
            rr = $urandom_range(0, 1);
            run_access(we, a, w, sz, us, rw, rd, rv, rr, 0,
                       we ? 32'h0 : model_load(rw, lane, sz, us), 2'd0, 2 + rd + rv,
                       model_mask(lane, sz), model_wdata(w, sz));
        end

        // Reset while in WAIT: store accepted, then reset
        @(negedge clk);
        req_valid = 1; req_wen = 1; req_addr = 32'h8000_0010; req_wdata = 32'h11223344; req_size = 2'd2;
        @(negedge clk);
        req_valid = 0;
        check_eq("pre_rst_mem_valid", m1.mem_valid, 1);
        m1.mem_ready = 1;
        @(negedge clk);
        m1.mem_ready = 0;
        check_eq("pre_rst_mem_valid_wait", m1.mem_valid, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check_reset_vals("midrst");
        m1.mem_rvalid = 1; m1.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        m1.mem_rvalid = 0;
        check_eq("stray_rvalid_resp", resp_valid, 0);
        @(negedge clk);
        check_eq("stray_rvalid_resp2", resp_valid, 0);
        check_eq("stray_rvalid_ready", req_ready, 1);

        // Timeout on the short-timeout instance, memory never ready
        check_eq("tmo_req_ready", req_ready2, 1);
        req_valid2 = 1; req_wen2 = 0; req_addr2 = 32'h8000_0000; req_size2 = 2'd2;
        e.rdata = 32'h0; e.err = 2'd2;
        sb.push_back(e);
        @(negedge clk);
        req_valid2 = 0;
        for (int c = 1; c < 10; c++) begin
            check_eq("tmo_mem_valid_hi", m2.mem_valid, 1);
            check_eq("tmo_resp_early", resp_valid2, 0);
            @(negedge clk);
        end
        check_eq("tmo_resp_valid", resp_valid2, 1);
        check_eq("tmo_mem_valid_lo", m2.mem_valid, 0);
        if (resp_valid2) begin
            e = sb.pop_front();
            check_eq("tmo_resp_err", resp_err2, e.err);
            check_eq("tmo_resp_rdata", resp_rdata2, e.rdata);
        end
        resp_ready2 = 1;
        @(negedge clk);
        resp_ready2 = 0;
        check_eq("tmo_req_ready_after", req_ready2, 1);
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
